// File: rtl/parking_lane_sequencer.sv
// parking_lane_sequencer: lane sensor conditioning, entry/exit event issue and gate sequencing; define PARKING_SEQ_TIMEOUT_EN for the GATE_OPEN timeout fault
module parking_lane_sequencer #(
  parameter int DEBOUNCE_CYCLES     = 4,
  parameter int GATE_HOLD_CYCLES    = 16,
  parameter int GATE_TIMEOUT_CYCLES = 64,
  parameter int CNT_W               = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       entry_req_raw,
  input  logic       exit_req_raw,
  input  logic [1:0] exit_slot_raw,
  input  logic       gate_pass_raw,
  input  logic       door_open,
  input  logic       full_light,
  input  logic [3:0] best_slot,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exit_location,
  output logic       gate_cmd,
  output logic [3:0] assigned_slot,
  output logic       deny,
  output logic       busy,
  output logic       gate_fault
);
  typedef enum logic [1:0] {IDLE, ENTRY_ISSUE, GATE_OPEN, GATE_HOLD} state_t;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(GATE_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(GATE_TIMEOUT_CYCLES - 1);
  // bit 0 entry loop, bit 1 exit loop, bit 2 pass beam
  logic [2:0] raw, s1_q, s2_q, lvl_q, lvl_d, rise_q, rise_d;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];
  logic [1:0] slot_s1_q, slot_s2_q, slot_q, slot_d;
  logic entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
  logic exit_sensor_q, exit_sensor_d, deny_q, deny_d, gate_fault_q, gate_fault_d;
  logic [3:0] assigned_q, assigned_d;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  state_t state_q, state_d;
  logic entry_rise, exit_rise, pass_rise;
  assign raw = {gate_pass_raw, exit_req_raw, entry_req_raw};
  assign entry_rise = rise_q[0];
  assign exit_rise = rise_q[1];
  assign pass_rise = rise_q[2];
  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) lvl_d[i] = s2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    rise_d = lvl_d & ~lvl_q;
  end
  // Pending flags, exit issuer and main lane FSM; exit pending blocks the IDLE launch so the two events never collide
  always_comb begin
    state_d = state_q;
    entry_pend_d = entry_pend_q | entry_rise;
    exit_pend_d = exit_pend_q ? 1'b0 : exit_rise;
    slot_d = (!exit_pend_q && exit_rise) ? slot_s2_q : slot_q;
    exit_sensor_d = exit_pend_q;
    deny_d = 1'b0;
    assigned_d = assigned_q;
    gate_cnt_d = gate_cnt_q;
    gate_fault_d = gate_fault_q;
    case (state_q)
      IDLE: begin
        if (entry_pend_q && !exit_pend_q) begin
          if (full_light) begin
            deny_d = 1'b1;
            entry_pend_d = 1'b0;
          end else state_d = ENTRY_ISSUE;
        end
      end
      ENTRY_ISSUE: begin
        entry_pend_d = 1'b0;
        state_d = door_open ? GATE_OPEN : IDLE;
        deny_d = !door_open;
        assigned_d = door_open ? best_slot : assigned_q;
        gate_cnt_d = TO_LOAD;
      end
      GATE_OPEN: begin
        if (pass_rise) begin
          state_d = GATE_HOLD;
          gate_cnt_d = HOLD_LOAD;
        end
`ifdef PARKING_SEQ_TIMEOUT_EN
        else if (gate_cnt_q == '0) begin
          state_d = IDLE;
          gate_fault_d = 1'b1;
        end else gate_cnt_d = gate_cnt_q - 1'b1;
`endif
      end
      GATE_HOLD: begin
        if (pass_rise) gate_cnt_d = HOLD_LOAD;
        else if (gate_cnt_q == '0) state_d = IDLE;
        else gate_cnt_d = gate_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      lvl_q <= '0;
      rise_q <= '0;
      db_cnt_q <= '{default: '0};
      slot_s1_q <= '0;
      slot_s2_q <= '0;
      slot_q <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q <= 1'b0;
      exit_sensor_q <= 1'b0;
      deny_q <= 1'b0;
      assigned_q <= '0;
      gate_cnt_q <= '0;
      gate_fault_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
      db_cnt_q <= db_cnt_d;
      slot_s1_q <= exit_slot_raw;
      slot_s2_q <= slot_s1_q;
      slot_q <= slot_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q <= exit_pend_d;
      exit_sensor_q <= exit_sensor_d;
      deny_q <= deny_d;
      assigned_q <= assigned_d;
      gate_cnt_q <= gate_cnt_d;
      gate_fault_q <= gate_fault_d;
      state_q <= state_d;
    end
  end
  assign entry_sensor = state_q == ENTRY_ISSUE;
  assign exit_sensor = exit_sensor_q;
  assign exit_location = exit_sensor_q ? slot_q : 2'b00;
  assign gate_cmd = state_q == GATE_OPEN || state_q == GATE_HOLD;
  assign assigned_slot = assigned_q;
  assign deny = deny_q;
  assign busy = state_q != IDLE;
  assign gate_fault = gate_fault_q;
endmodule

// File: tb/tb_parking_lane_sequencer.sv
// tb_parking_lane_sequencer: vector table, directed corner sequences and a randomized event-level reference model
module tb_parking_lane_sequencer;
  localparam int D = 4;
  localparam int NR = 600;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic entry_req_raw = 1'b0, exit_req_raw = 1'b0, gate_pass_raw = 1'b0;
  logic [1:0] exit_slot_raw = 2'b00;
  logic door_open, full_light = 1'b0, door_policy = 1'b0;
  logic [3:0] best_slot = 4'b0000;
  logic entry_sensor, exit_sensor, gate_cmd, deny, busy, gate_fault;
  logic [1:0] exit_location;
  logic [3:0] assigned_slot;
  int total = 0, bad = 0;
  typedef struct {
    int len;
    logic full, door;
    logic [3:0] slot;
    int n_ent, n_deny;
    logic gate;
    logic [3:0] asg;
  } vec_t;
  vec_t tbl [8];
  logic exp_ex [NR + 40];
  logic [1:0] exp_loc [NR + 40];
  logic exp_dn [NR + 40];
  int ex_hi, ex_lo, en_hi, en_lo, len, ex_new;
  int n_ent, n_deny, first, first_deny, ex_t, en_t, both;
  logic [1:0] ex_loc;
  // Occupancy FSM stand-in: answers combinationally while entry_sensor is high
  assign door_open = entry_sensor & door_policy;
  parking_lane_sequencer #(.DEBOUNCE_CYCLES(D), .GATE_HOLD_CYCLES(16), .GATE_TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .entry_req_raw(entry_req_raw), .exit_req_raw(exit_req_raw),
    .exit_slot_raw(exit_slot_raw), .gate_pass_raw(gate_pass_raw), .door_open(door_open),
    .full_light(full_light), .best_slot(best_slot), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .exit_location(exit_location), .gate_cmd(gate_cmd), .assigned_slot(assigned_slot), .deny(deny),
    .busy(busy), .gate_fault(gate_fault)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic close_gate();
    int t;
    gate_pass_raw = 1'b1;
    repeat (D + 2) tick();
    gate_pass_raw = 1'b0;
    t = 0;
    while (busy && t < 60) begin
      tick();
      t++;
    end
    check("close_idle", busy, 0);
  endtask
  task automatic gate_cycle(input logic with_exit, input logic [3:0] slot);
    int t;
    full_light = 1'b0;
    door_policy = 1'b1;
    best_slot = slot;
    entry_req_raw = 1'b1;
    t = 0;
    while (!entry_sensor && t < 40) begin
      tick();
      t++;
    end
    check("grant_latency", t, D + 4);
    check("grant_gate_in_issue", gate_cmd, 0);
    entry_req_raw = 1'b0;
    tick();
    check("grant_gate_open", gate_cmd, 1);
    check("grant_slot", assigned_slot, slot);
    repeat (9) tick();
    gate_pass_raw = 1'b1;
    if (with_exit) begin
      exit_req_raw = 1'b1;
      exit_slot_raw = 2'b01;
    end
    for (int i = 1; i <= D + 20; i++) begin
      tick();
      if (i == D + 2) begin
        gate_pass_raw = 1'b0;
        exit_req_raw = 1'b0;
      end
      check("hold_gate", gate_cmd, i <= D + 18);
      check("hold_exit", exit_sensor, with_exit && i == D + 4);
      check("hold_loc", exit_location, (with_exit && i == D + 4) ? 2'b01 : 2'b00);
      check("hold_no_entry", entry_sensor, 0);
    end
    check("hold_busy", busy, 0);
  endtask
  initial begin
    tbl[0] = '{3, 1'b0, 1'b1, 4'b0001, 0, 0, 1'b0, 4'b0000};
    tbl[1] = '{6, 1'b1, 1'b1, 4'b0001, 0, 1, 1'b0, 4'b0000};
    tbl[2] = '{6, 1'b0, 1'b0, 4'b0010, 1, 1, 1'b0, 4'b0000};
    tbl[3] = '{6, 1'b0, 1'b1, 4'b0100, 1, 0, 1'b1, 4'b0100};
    tbl[4] = '{4, 1'b0, 1'b1, 4'b1000, 1, 0, 1'b1, 4'b1000};
    tbl[5] = '{6, 1'b0, 1'b0, 4'b0001, 1, 1, 1'b0, 4'b1000};
    tbl[6] = '{1, 1'b1, 1'b0, 4'b0001, 0, 0, 1'b0, 4'b1000};
    tbl[7] = '{4, 1'b1, 1'b0, 4'b0010, 0, 1, 1'b0, 4'b1000};
    // reset with the entry loop held high: all outputs low, then one entry event after release
    entry_req_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outputs", {entry_sensor, exit_sensor, exit_location, gate_cmd, assigned_slot, deny, busy, gate_fault}, 0);
    end
    reset_n = 1'b1;
    n_ent = 0;
    first = -1;
    for (int t = 1; t <= D + 12; t++) begin
      tick();
      if (entry_sensor) begin
        n_ent++;
        if (first < 0) first = t;
      end
    end
    check("reset_first_entry", first, D + 4);
    check("reset_entry_count", n_ent, 1);
    entry_req_raw = 1'b0;
    repeat (D + 4) tick();
    // vector table of single entry attempts
    for (int i = 0; i < 8; i++) begin
      full_light = tbl[i].full;
      door_policy = tbl[i].door;
      best_slot = tbl[i].slot;
      entry_req_raw = 1'b1;
      n_ent = 0;
      n_deny = 0;
      first = -1;
      first_deny = -1;
      for (int t = 1; t <= D + 8; t++) begin
        if (t == tbl[i].len + 1) entry_req_raw = 1'b0;
        tick();
        if (entry_sensor) begin
          n_ent++;
          if (first < 0) first = t;
        end
        if (deny) begin
          n_deny++;
          if (first_deny < 0) first_deny = t;
        end
      end
      check("tbl_entry_count", n_ent, tbl[i].n_ent);
      check("tbl_deny_count", n_deny, tbl[i].n_deny);
      check("tbl_entry_time", first, tbl[i].n_ent != 0 ? D + 4 : -1);
      check("tbl_deny_time", first_deny, tbl[i].n_deny == 0 ? -1 : (tbl[i].full ? D + 4 : D + 5));
      check("tbl_gate", gate_cmd, tbl[i].gate);
      check("tbl_assigned", assigned_slot, tbl[i].asg);
      if (gate_cmd) close_gate();
      repeat (4) tick();
    end
    // granted entries with exact gate timing, second one with an exit during hold
    gate_cycle(1'b0, 4'b0100);
    repeat (D + 4) tick();
    gate_cycle(1'b1, 4'b0001);
    repeat (D + 4) tick();
    // simultaneous entry and exit
    full_light = 1'b0;
    door_policy = 1'b0;
    entry_req_raw = 1'b1;
    exit_req_raw = 1'b1;
    exit_slot_raw = 2'b10;
    ex_t = -1;
    en_t = -1;
    both = 0;
    ex_loc = 2'b00;
    for (int t = 1; t <= D + 10; t++) begin
      tick();
      if (t == D + 2) begin
        entry_req_raw = 1'b0;
        exit_req_raw = 1'b0;
      end
      if (exit_sensor && ex_t < 0) begin
        ex_t = t;
        ex_loc = exit_location;
      end
      if (entry_sensor && en_t < 0) en_t = t;
      if (entry_sensor && exit_sensor) both++;
    end
    check("coll_exit_time", ex_t, D + 4);
    check("coll_exit_loc", ex_loc, 2'b10);
    check("coll_entry_time", en_t, D + 5);
    check("coll_both", both, 0);
    repeat (D + 4) tick();
    // gate left open with no pass beam
    full_light = 1'b0;
    door_policy = 1'b1;
    best_slot = 4'b0010;
    entry_req_raw = 1'b1;
    first = 0;
    while (!entry_sensor && first < 40) begin
      tick();
      first++;
    end
    entry_req_raw = 1'b0;
    tick();
    check("to_gate_open", gate_cmd, 1);
    for (int j = 1; j <= 70; j++) begin
      tick();
`ifdef PARKING_SEQ_TIMEOUT_EN
      if (j == 63) check("to_gate_before", gate_cmd, 1);
      if (j == 64) begin
        check("to_gate_closed", gate_cmd, 0);
        check("to_fault", gate_fault, 1);
      end
`else
      if (j == 70) begin
        check("to_gate_still_open", gate_cmd, 1);
        check("to_no_fault", gate_fault, 0);
      end
`endif
    end
    close_gate();
    // randomized exits, refused entries and beam noise against an event-level model
    full_light = 1'b1;
    door_policy = 1'b0;
    entry_req_raw = 1'b0;
    exit_req_raw = 1'b0;
    gate_pass_raw = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rnd_fault_cleared", gate_fault, 0);
    reset_n = 1'b1;
    for (int s = 0; s < NR + 40; s++) begin
      exp_ex[s] = 1'b0;
      exp_loc[s] = 2'b00;
      exp_dn[s] = 1'b0;
    end
    ex_hi = 0;
    ex_lo = 0;
    en_hi = 0;
    en_lo = 0;
    for (int r = 0; r < NR + 30; r++) begin
      ex_new = 0;
      if (ex_hi > 0) begin
        ex_hi--;
        if (ex_hi == 0) begin
          exit_req_raw = 1'b0;
          ex_lo = $urandom_range(D + 1, D + 8);
        end
      end else if (ex_lo > 0) ex_lo--;
      else if (r < NR && $urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 2 * D + 2);
        exit_req_raw = 1'b1;
        exit_slot_raw = 2'($urandom_range(0, 3));
        ex_hi = len;
        if (len >= D) begin
          ex_new = 1;
          exp_ex[r + D + 4] = 1'b1;
          exp_loc[r + D + 4] = exit_slot_raw;
        end
      end
      if (en_hi > 0) begin
        en_hi--;
        if (en_hi == 0) begin
          entry_req_raw = 1'b0;
          en_lo = $urandom_range(D + 1, D + 8);
        end
      end else if (en_lo > 0) en_lo--;
      else if (r < NR && $urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 2 * D + 2);
        entry_req_raw = 1'b1;
        en_hi = len;
        if (len >= D) exp_dn[r + D + 4 + ex_new] = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) gate_pass_raw = ~gate_pass_raw;
      tick();
      check("rnd_exit", exit_sensor, exp_ex[r + 1]);
      check("rnd_loc", exit_location, exp_loc[r + 1]);
      check("rnd_deny", deny, exp_dn[r + 1]);
      check("rnd_entry", entry_sensor, 0);
      check("rnd_gate", gate_cmd, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
